// File: rtl/sabr_prod_accum.sv
// sabr_prod_accum: sums batch_len unsigned products, then rounds half-up, shifts by SHIFT and saturates to OUT_W.
// Result valid 1 cycle after last beat, held until out_ready; in_ready only in ACC; optional ovf via SABR_PROD_ACCUM_OVF_EN.
module sabr_prod_accum #(
  parameter int IN_W  = 75,
  parameter int ACC_W = 96,
  parameter int CNT_W = 16,
  parameter int SHIFT = 32,
  parameter int OUT_W = 40
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] batch_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
`ifdef SABR_PROD_ACCUM_OVF_EN
  output logic             done,
  output logic             ovf
`else
  output logic             done
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_add;
  logic             acc_sat;
  logic [ACC_W:0]   rnd_sum;
  logic [ACC_W:0]   rnd_shr;
  logic             out_sat;
  logic [OUT_W-1:0] out_rnd;

  // Rounding is taken on the post-add value so the last beat lands in the registered result.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
    acc_sat = acc_sum[ACC_W];
    acc_add = acc_sat ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    rnd_sum = {1'b0, acc_add} + RND;
    rnd_shr = rnd_sum >> SHIFT;
    out_sat = |(rnd_shr >> OUT_W);
    out_rnd = out_sat ? {OUT_W{1'b1}} : rnd_shr[OUT_W-1:0];
  end

`ifdef SABR_PROD_ACCUM_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef SABR_PROD_ACCUM_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = batch_len;
          acc_d = '0;
          cnt_d = '0;
`ifdef SABR_PROD_ACCUM_OVF_EN
          ovf_d = 1'b0;
`endif
          if (batch_len == '0) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_data_d  = '0;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d = acc_add;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SABR_PROD_ACCUM_OVF_EN
          ovf_d = ovf_q | acc_sat;
`endif
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_data_d  = out_rnd;
`ifdef SABR_PROD_ACCUM_OVF_EN
            ovf_d       = ovf_q | acc_sat | out_sat;
`endif
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef SABR_PROD_ACCUM_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef SABR_PROD_ACCUM_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = out_valid_q & out_ready;

endmodule

// File: tb/tb_sabr_prod_accum.sv
// Bench for sabr_prod_accum: directed vector table, reset/ignored-start sequence, random batches vs arithmetic model.
module tb_sabr_prod_accum;
  localparam int IN_W  = 75;
  localparam int CNT_W = 16;
  localparam int OUT_W = 40;
  localparam logic [OUT_W-1:0] OUT_MAX = {OUT_W{1'b1}};

  logic             ap_clk = 1'b0;
  logic             ap_rst, start, in_valid, out_ready;
  logic [CNT_W-1:0] batch_len;
  logic [IN_W-1:0]  in_data;
  logic             in_ready, out_valid, busy, done;
  logic [OUT_W-1:0] out_data;
`ifdef SABR_PROD_ACCUM_OVF_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 ap_clk = ~ap_clk;

  sabr_prod_accum dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .start     (start),
    .batch_len (batch_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
`ifdef SABR_PROD_ACCUM_OVF_EN
    .done      (done),
    .ovf       (ovf)
`else
    .done      (done)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Plain-integer reference: sum, clamp to the accumulator range, round half-up, clamp to OUT_W.
  function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] p[$]);
    logic [127:0] s;
    logic [127:0] r;
    logic         sat;
    s   = 128'd0;
    sat = 1'b0;
    foreach (p[i]) s += 128'(p[i]);
    if (s > (128'd1 << 96) - 128'd1) begin
      s   = (128'd1 << 96) - 128'd1;
      sat = 1'b1;
    end
    r = (s + (128'd1 << 31)) >> 32;
    if (r > 128'(OUT_MAX)) return {1'b1, OUT_MAX};
    return {sat, r[OUT_W-1:0]};
  endfunction

  task automatic run_batch(input string nm, input int len, input logic [IN_W-1:0] p[$],
                           input bit gap, input int hold, input logic [OUT_W-1:0] exp,
                           input bit exp_ovf);
    start     = 1'b1;
    batch_len = CNT_W'(len);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk({nm, ".idle_in_ready"}, in_ready, 0);
    chk({nm, ".idle_busy"}, busy, 0);
    tick();
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gap && (i % 2 == 0)) begin
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
        #1;
        chk({nm, ".gap_in_ready"}, in_ready, 1);
        chk({nm, ".gap_out_valid"}, out_valid, 0);
        tick();
      end
      in_valid = 1'b1;
      in_data  = p[i];
      #1;
      chk({nm, ".beat_in_ready"}, in_ready, 1);
      chk({nm, ".beat_busy"}, busy, 1);
      tick();
    end
    // Extra offered product must not be taken once the batch is complete.
    in_valid = 1'b1;
    in_data  = IN_W'({$urandom, $urandom, $urandom});
    #1;
    chk({nm, ".out_valid"}, out_valid, 1);
    chk({nm, ".out_data"}, out_data, exp);
    chk({nm, ".out_in_ready"}, in_ready, 0);
    chk({nm, ".out_done_lo"}, done, 0);
`ifdef SABR_PROD_ACCUM_OVF_EN
    chk({nm, ".ovf"}, ovf, exp_ovf);
`else
    if (exp_ovf) total = total + 0;
`endif
    for (int h = 0; h < hold; h++) begin
      start     = 1'b1;
      batch_len = '0;
      tick();
      chk({nm, ".hold_valid"}, out_valid, 1);
      chk({nm, ".hold_data"}, out_data, exp);
      chk({nm, ".hold_in_ready"}, in_ready, 0);
      chk({nm, ".hold_done"}, done, 0);
    end
    start     = 1'b1;
    batch_len = '0;
    out_ready = 1'b1;
    #1;
    chk({nm, ".done"}, done, 1);
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk({nm, ".post_valid"}, out_valid, 0);
    chk({nm, ".post_busy"}, busy, 0);
    chk({nm, ".post_done"}, done, 0);
  endtask

  typedef struct {
    int                     len;
    logic [3:0][IN_W-1:0]   p;
    bit                     gap;
    int                     hold;
    logic [OUT_W-1:0]       exp;
  } vec_t;

  function automatic vec_t mk(input int len, input logic [IN_W-1:0] p0, input logic [IN_W-1:0] p1,
                              input logic [IN_W-1:0] p2, input bit gap, input int hold,
                              input logic [OUT_W-1:0] exp);
    vec_t v;
    v.len  = len;
    v.p[0] = p0;
    v.p[1] = p1;
    v.p[2] = p2;
    v.p[3] = '0;
    v.gap  = gap;
    v.hold = hold;
    v.exp  = exp;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             tv[8];
    logic [IN_W-1:0]  q[$];
    logic [IN_W-1:0]  one32;
    logic [OUT_W:0]   m;

    one32 = IN_W'(1) << 32;
    tv[0] = mk(3, one32, one32 * 2, one32 * 3, 1'b0, 0, 40'd6);
    tv[1] = mk(1, IN_W'(64'h8000_0000), '0, '0, 1'b0, 0, 40'd1);
    tv[2] = mk(1, IN_W'(64'h7FFF_FFFF), '0, '0, 1'b0, 0, 40'd0);
    tv[3] = mk(0, '0, '0, '0, 1'b0, 1, 40'd0);
    tv[4] = mk(2, one32 * 5, one32 * 7, '0, 1'b0, 5, 40'd12);
    tv[5] = mk(1, IN_W'(1) << 74, '0, '0, 1'b0, 0, OUT_MAX);
    tv[6] = mk(1, IN_W'(64'h1_8000_0000), '0, '0, 1'b0, 1, 40'd2);
    tv[7] = mk(2, one32 * 5, one32 * 7, '0, 1'b1, 2, 40'd12);

    ap_rst    = 1'b1;
    start     = 1'b0;
    batch_len = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
`ifdef SABR_PROD_ACCUM_OVF_EN
    chk("rst.ovf", ovf, 0);
`endif
    ap_rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      q = {};
      for (int k = 0; k < tv[i].len; k++) q.push_back(tv[i].p[k]);
      m = model(q);
      run_batch($sformatf("vec%0d", i), tv[i].len, q, tv[i].gap, tv[i].hold, tv[i].exp, m[OUT_W]);
    end

    // Reset in the middle of a 4-beat batch discards it.
    start     = 1'b1;
    batch_len = CNT_W'(4);
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = one32;
      tick();
    end
    ap_rst = 1'b1;
    tick();
    chk("midrst.in_ready", in_ready, 0);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.out_data", out_data, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    ap_rst   = 1'b0;
    in_valid = 1'b0;
    q = {};
    q.push_back(one32 * 9);
    run_batch("after_rst", 1, q, 1'b0, 2, 40'd9, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int len;
      len = $urandom_range(0, 6);
      q = {};
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 2))
          0:       q.push_back(IN_W'($urandom));
          1:       q.push_back(IN_W'({$urandom, $urandom}));
          default: q.push_back(IN_W'({$urandom, $urandom, $urandom}));
        endcase
      end
      m = model(q);
      run_batch($sformatf("rnd%0d", n), len, q, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), m[OUT_W-1:0], m[OUT_W]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
